// File: rtl/cache_pkg.sv
`default_nettype none
// ============================================================================
// Module      : cache_pkg
// Description : Shared widths, FSM state encoding and word-select helper for
//               the direct-mapped read-only cache controller.
// Revision    : 1.0 - initial release
// ============================================================================
package cache_pkg;

    localparam int ADDR_W   = 15;
    localparam int WORD_W   = 32;
    localparam int BLOCK_W  = 128;
    localparam int OFFSET_W = 2;
    localparam int INDEX_W  = 8;
    localparam int TAG_W    = 5;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LOOKUP = 3'd1,
        ST_WAIT   = 3'd2,
        ST_FILL   = 3'd3,
        ST_RESP   = 3'd4
    } state_e;

    // Word 0 of a block sits in the most significant 32 bits.
    function automatic logic [WORD_W-1:0] select_word(
        input logic [BLOCK_W-1:0]  blk,
        input logic [OFFSET_W-1:0] off
    );
        logic [WORD_W-1:0] w;
        case (off)
            2'd0:    w = blk[127:96];
            2'd1:    w = blk[95:64];
            2'd2:    w = blk[63:32];
            default: w = blk[31:0];
        endcase
        return w;
    endfunction

endpackage
`default_nettype wire

// File: rtl/cache_if.sv
`default_nettype none
// ============================================================================
// Module      : cache_if
// Description : CPU request/response and memory fetch signals of the cache.
// Revision    : 1.0 - initial release
// ============================================================================
interface cache_if
    import cache_pkg::*;
();
    logic               req_valid;
    logic [ADDR_W-1:0]  req_addr;
    logic               req_ready;
    logic               rsp_valid;
    logic [WORD_W-1:0]  rsp_data;
    logic               mem_rd;
    logic [ADDR_W-1:0]  mem_addr;
    logic [BLOCK_W-1:0] mem_data;

    modport slave (
        input  req_valid, req_addr, mem_data,
        output req_ready, rsp_valid, rsp_data, mem_rd, mem_addr
    );

    modport master (
        output req_valid, req_addr, mem_data,
        input  req_ready, rsp_valid, rsp_data, mem_rd, mem_addr
    );
endinterface
`default_nettype wire

// File: rtl/cache_line_store.sv
`default_nettype none
// ============================================================================
// Module      : cache_line_store
// Description : Valid/tag/data arrays, one async read port, one line write.
// Revision    : 1.0 - initial release
// ============================================================================
module cache_line_store
    import cache_pkg::*;
#(
    parameter int NUM_LINES  = 256,
    parameter int LINE_IDX_W = $clog2(NUM_LINES),
    parameter int LINE_TAG_W = ADDR_W - OFFSET_W - LINE_IDX_W
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [LINE_IDX_W-1:0] rd_index,
    output logic                  rd_valid,
    output logic [LINE_TAG_W-1:0] rd_tag,
    output logic [BLOCK_W-1:0]    rd_data,
    input  logic                  wr_en,
    input  logic [LINE_IDX_W-1:0] wr_index,
    input  logic [LINE_TAG_W-1:0] wr_tag,
    input  logic [BLOCK_W-1:0]    wr_data
);

    logic [NUM_LINES-1:0]  valid_q;
    logic [LINE_TAG_W-1:0] tag_q  [NUM_LINES];
    logic [BLOCK_W-1:0]    data_q [NUM_LINES];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= '0;
        end else if (wr_en) begin
            valid_q[wr_index] <= 1'b1;
        end
    end

    // Tag and data carry no reset; a cleared valid bit masks them.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            tag_q[wr_index]  <= wr_tag;
            data_q[wr_index] <= wr_data;
        end
    end

    assign rd_valid = valid_q[rd_index];
    assign rd_tag   = tag_q[rd_index];
    assign rd_data  = data_q[rd_index];

endmodule
`default_nettype wire

// File: rtl/cache_controller.sv
`default_nettype none
// ============================================================================
// Module      : cache_controller
// Description : Direct-mapped, 4-word-line, read-only cache with blocking
//               miss handling and wrapping hit/miss counters.
// Revision    : 1.0 - initial release
// ============================================================================
module cache_controller
    import cache_pkg::*;
#(
    parameter int MEM_LATENCY = 4,
    parameter int NUM_LINES   = 256
) (
    input  logic        clk,
    input  logic        rst,
    cache_if.slave      bus,
    output logic [15:0] hit_count,
    output logic [15:0] miss_count
);

    localparam int LINE_IDX_W = $clog2(NUM_LINES);
    localparam int LINE_TAG_W = ADDR_W - OFFSET_W - LINE_IDX_W;

    state_e              state_q,    state_d;
    logic [ADDR_W-1:0]   addr_q,     addr_d;
    logic [3:0]          wait_cnt_q, wait_cnt_d;
    logic [WORD_W-1:0]   rsp_data_q, rsp_data_d;
    logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
    logic [15:0]         hit_q,      hit_d;
    logic [15:0]         miss_q,     miss_d;

    logic [LINE_IDX_W-1:0] w_index;
    logic [LINE_TAG_W-1:0] w_tag;
    logic [OFFSET_W-1:0]   w_offset;
    logic                  w_rd_valid;
    logic [LINE_TAG_W-1:0] w_rd_tag;
    logic [BLOCK_W-1:0]    w_rd_data;
    logic                  w_hit;
    logic                  w_line_wr;

    assign w_offset = addr_q[OFFSET_W-1:0];
    assign w_index  = addr_q[OFFSET_W +: LINE_IDX_W];
    assign w_tag    = addr_q[ADDR_W-1 -: LINE_TAG_W];
    assign w_hit    = w_rd_valid && (w_rd_tag == w_tag);

    cache_line_store #(
        .NUM_LINES (NUM_LINES)
    ) u_store (
        .clk      (clk),
        .rst      (rst),
        .rd_index (w_index),
        .rd_valid (w_rd_valid),
        .rd_tag   (w_rd_tag),
        .rd_data  (w_rd_data),
        .wr_en    (w_line_wr),
        .wr_index (w_index),
        .wr_tag   (w_tag),
        .wr_data  (bus.mem_data)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            addr_q     <= '0;
            wait_cnt_q <= '0;
            rsp_data_q <= '0;
            mem_addr_q <= '0;
            hit_q      <= '0;
            miss_q     <= '0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            wait_cnt_q <= wait_cnt_d;
            rsp_data_q <= rsp_data_d;
            mem_addr_q <= mem_addr_d;
            hit_q      <= hit_d;
            miss_q     <= miss_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        wait_cnt_d = wait_cnt_q;
        rsp_data_d = rsp_data_q;
        mem_addr_d = mem_addr_q;
        hit_d      = hit_q;
        miss_d     = miss_q;
        w_line_wr  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (bus.req_valid) begin
                    addr_d  = bus.req_addr;
                    state_d = ST_LOOKUP;
                end
            end
            ST_LOOKUP: begin
                if (w_hit) begin
                    rsp_data_d = select_word(w_rd_data, w_offset);
                    hit_d      = hit_q + 16'd1;
                    state_d    = ST_RESP;
                end else begin
                    miss_d     = miss_q + 16'd1;
                    mem_addr_d = {addr_q[ADDR_W-1:OFFSET_W], {OFFSET_W{1'b0}}};
                    wait_cnt_d = '0;
                    state_d    = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (wait_cnt_q == 4'(MEM_LATENCY - 1)) begin
                    state_d = ST_FILL;
                end else begin
                    wait_cnt_d = wait_cnt_q + 4'd1;
                end
            end
            ST_FILL: begin
                // Requested word comes straight from the fetched block.
                w_line_wr  = 1'b1;
                rsp_data_d = select_word(bus.mem_data, w_offset);
                state_d    = ST_RESP;
            end
            ST_RESP: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign bus.req_ready = (state_q == ST_IDLE);
    assign bus.rsp_valid = (state_q == ST_RESP);
    assign bus.rsp_data  = rsp_data_q;
    assign bus.mem_rd    = (state_q == ST_WAIT) || (state_q == ST_FILL);
    assign bus.mem_addr  = mem_addr_q;
    assign hit_count     = hit_q;
    assign miss_count    = miss_q;

endmodule
`default_nettype wire
